// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the MEM stage of the pipelined CPU. It accepts one
// request at a time over a valid/ready handshake. Each request is held for
// LATENCY wait states. The responder then commits a byte-enabled write or
// returns read data with a single-cycle response strobe. While a request is
// outstanding it drives a stall that holds the pipeline.
//
// Parameters
//   LATENCY     wait-state cycles between acceptance and response (0..15)
//   DEPTH_LOG2  word-address width; array holds 2**DEPTH_LOG2 32-bit words
//
// Ports
//   Clock       in   single clock, rising edge
//   Resetn      in   synchronous reset, active HIGH despite the legacy name
//   req_valid   in   MEM stage has a request (held until the response cycle)
//   req_we      in   1 = write, 0 = read
//   req_addr    in   word address
//   req_wdata   in   write data
//   req_be      in   write byte enables, bit i -> bits [8i+7:8i]
//   req_ready   out  request can be accepted this cycle (IDLE only)
//   resp_valid  out  one-cycle completion strobe
//   resp_rdata  out  read data, held until the next read completes
//   mem_stall   out  pipeline hold: req_valid && !resp_valid
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [DEPTH_LOG2-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  mem_stall
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            counter;
    logic [3:0]            counter_next;
    logic                  accept;
    logic                  commit;

    logic                  cap_we;
    logic [DEPTH_LOG2-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [3:0]            cap_be;

    logic                  op_we;
    logic [DEPTH_LOG2-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic [3:0]            op_be;

    logic [31:0]           mem [DEPTH];

    // Next-state and handshake logic
    always_comb begin
        state_next   = state;
        counter_next = counter;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next   = WAIT;
                        counter_next = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                counter_next = counter - 4'd1;
                if (counter == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory operation happens on the edge that enters RESP.
    assign commit = (state_next == RESP) && (state != RESP);

    // With LATENCY=0 the commit edge is also the accept edge. In that case
    // the capture registers are not loaded yet, so the live request is used.
    assign op_we    = (state == IDLE) ? req_we    : cap_we;
    assign op_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign op_be    = (state == IDLE) ? req_be    : cap_be;

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state      <= IDLE;
            counter    <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_be     <= '0;
            resp_rdata <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[DEPTH_LOG2'(i)] <= '0;
            end
        end else begin
            state   <= state_next;
            counter <= counter_next;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end
            if (commit) begin
                if (op_we) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (op_be[b]) begin
                            mem[op_addr][8*b +: 8] <= op_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    resp_rdata <= mem[op_addr];
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_stall  = req_valid && !resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders side by side: index 0 uses LATENCY=2 and index 1 uses
// LATENCY=0. Directed vectors come from a table, followed by a mid-operation
// reset sequence and random traffic. Every response is compared with a
// word-array reference model.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [1:0][4:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0] req_be;
    logic [1:0]      req_ready;
    logic [1:0]      resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]      mem_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mm [2][32];
    logic [31:0] mr [2];
    int          lat_of [2];

    typedef struct {
        int          s;
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          scr;
        bit          has_exp;
        logic [31:0] expv;
    } vec_t;

    vec_t tbl [$];

    dmem_responder #(.LATENCY(2), .DEPTH_LOG2(5)) dut_l2 (
        .Clock      (clk),
        .Resetn     (rst),
        .req_valid  (req_valid[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_be     (req_be[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .mem_stall  (mem_stall[0])
    );

    dmem_responder #(.LATENCY(0), .DEPTH_LOG2(5)) dut_l0 (
        .Clock      (clk),
        .Resetn     (rst),
        .req_valid  (req_valid[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_be     (req_be[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .mem_stall  (mem_stall[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) mm[s][i] = '0;
            mr[s] = '0;
        end
    endtask

    // Entered and left at posedge+1. Request cycle, accept edge, then
    // lat wait cycles and one response cycle.
    task automatic xact(input int s, input bit we, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit scr, input bit has_exp,
                        input logic [31:0] expv);
        int lat;
        lat = lat_of[s];
        req_valid[1-s] = 1'b0;
        req_valid[s]   = 1'b1;
        req_we[s]      = we;
        req_addr[s]    = a;
        req_wdata[s]   = d;
        req_be[s]      = be;
        @(negedge clk);
        chk("ready_before_accept", 32'(req_ready[s]), 32'd1);
        chk("stall_request_cycle", 32'(mem_stall[s]), 32'd1);
        chk("resp_low_request_cycle", 32'(resp_valid[s]), 32'd0);
        @(posedge clk);
        #1;
        if (scr) begin
            req_addr[s]  = a ^ 5'd12;
            req_wdata[s] = ~d;
            req_be[s]    = ~be;
            req_we[s]    = ~we;
        end
        if (we) mm[s][a] = merge(mm[s][a], d, be);
        else    mr[s]    = mm[s][a];
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk("ready_low_busy", 32'(req_ready[s]), 32'd0);
            if (c <= lat) begin
                chk("resp_low_wait", 32'(resp_valid[s]), 32'd0);
                chk("stall_wait", 32'(mem_stall[s]), 32'd1);
            end else begin
                chk("resp_strobe", 32'(resp_valid[s]), 32'd1);
                chk("stall_released", 32'(mem_stall[s]), 32'd0);
                chk("rdata_model", resp_rdata[s], mr[s]);
                if (has_exp) chk("rdata_table", resp_rdata[s], expv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                chk("idle_ready", 32'(req_ready[s]), 32'd1);
                chk("idle_stall", 32'(mem_stall[s]), 32'd0);
                chk("idle_resp", 32'(resp_valid[s]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        lat_of[0] = 2;
        lat_of[1] = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        model_reset();

        // s, we, addr, wdata, be, scramble, has_exp, expected rdata
        tbl.push_back('{0, 1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000});
        tbl.push_back('{0, 1'b0, 5'd31, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000});
        tbl.push_back('{0, 1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 5'd5,  32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b1, 5'd7,  32'h11223344, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b1, 5'd7,  32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 5'd7,  32'h0,        4'h0, 1'b0, 1'b1, 32'h11BB33DD});
        tbl.push_back('{0, 1'b1, 5'd7,  32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'h11BB33DD});
        tbl.push_back('{0, 1'b0, 5'd7,  32'h0,        4'h0, 1'b0, 1'b1, 32'h11BB33DD});
        tbl.push_back('{0, 1'b0, 5'd5,  32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b1, 5'd12, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 5'd12, 32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D});
        tbl.push_back('{0, 1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000});
        tbl.push_back('{1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000});
        tbl.push_back('{1, 1'b1, 5'd5,  32'h0BADC0DE, 4'hF, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{1, 1'b0, 5'd5,  32'h0,        4'h0, 1'b0, 1'b1, 32'h0BADC0DE});
        tbl.push_back('{1, 1'b0, 5'd5,  32'h0,        4'h0, 1'b0, 1'b1, 32'h0BADC0DE});
        tbl.push_back('{1, 1'b0, 5'd31, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000});
        tbl.push_back('{1, 1'b1, 5'd31, 32'hA5A5A5A5, 4'h8, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{1, 1'b0, 5'd31, 32'h0,        4'h0, 1'b0, 1'b1, 32'hA5000000});
        tbl.push_back('{1, 1'b0, 5'd5,  32'h0,        4'h0, 1'b1, 1'b1, 32'h0BADC0DE});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_ready", 32'(req_ready[s]), 32'd1);
            chk("reset_stall", 32'(mem_stall[s]), 32'd0);
            chk("reset_resp", 32'(resp_valid[s]), 32'd0);
            chk("reset_rdata", resp_rdata[s], 32'd0);
        end
        @(posedge clk);
        #1;

        // Directed vectors; consecutive entries on one instance run back-to-back.
        foreach (tbl[i]) begin
            xact(tbl[i].s, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be,
                 tbl[i].scr, tbl[i].has_exp, tbl[i].expv);
        end
        idle(2);

        // Reset during the first wait cycle of a write to addr 3.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 5'd3;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        @(negedge clk);
        chk("midrst_stall", 32'(mem_stall[0]), 32'd1);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("midrst_wait_resp", 32'(resp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid[0]), 32'd0);
            chk("midrst_ready", 32'(req_ready[0]), 32'd1);
            chk("midrst_rdata", resp_rdata[0], 32'd0);
        end
        @(posedge clk);
        #1;
        xact(0, 1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 1'b1, 32'h00000000);
        xact(1, 1'b0, 5'd5, 32'h0, 4'h0, 1'b0, 1'b1, 32'h00000000);
        idle(1);

        // Random traffic against the model.
        for (int i = 0; i < 120; i++) begin
            int          s;
            bit          we;
            logic [4:0]  a;
            logic [31:0] d;
            logic [3:0]  be;
            s  = int'($urandom_range(1, 0));
            we = 1'($urandom_range(1, 0));
            a  = 5'($urandom_range(31, 0));
            d  = $urandom;
            be = 4'($urandom_range(15, 0));
            xact(s, we, a, d, be, 1'($urandom_range(1, 0)), 1'b0, 32'h0);
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 1)));
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
